fpu_core_arbiter: RTL and testbench
===================================

Name: fpu_core_arbiter

Overview:
Shares one FPU request/response port (the core-side slave of the FPU demux) among NB_CORES cores. Request side uses round-robin arbitration. Response side routes results back in issue order using an internal ID FIFO that tracks outstanding operations. Sits between the cluster cores and the FPU demux.

Parameters:
NB_CORES, 4, number of requesting cores (2..16)
DATA_WIDTH, 32, operand/result width
NB_ARGS, 3, operands per request
OPCODE_WIDTH, 6, opcode width
TYPE_WIDTH, 5, FPU type/select field width
DSFLAGS_WIDTH, 15, downstream flags width
USFLAGS_WIDTH, 5, upstream (result) flags width
MAX_OUTSTANDING, 4, ID FIFO depth; max in-flight ops (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
core_req_i  input  NB_CORES  per-core request
core_gnt_o  output  NB_CORES  per-core grant
core_type_i  input  NB_CORES*TYPE_WIDTH  per-core type select
core_operands_i  input  NB_CORES*NB_ARGS*DATA_WIDTH  per-core operands
core_op_i  input  NB_CORES*OPCODE_WIDTH  per-core opcode
core_flags_i  input  NB_CORES*DSFLAGS_WIDTH  per-core flags
core_rready_i  input  NB_CORES  per-core response ready
core_rvalid_o  output  NB_CORES  per-core response valid
core_rdata_o  output  DATA_WIDTH  result, broadcast to all cores
core_rflags_o  output  USFLAGS_WIDTH  result flags, broadcast
fpu_req_o  output  1  request to FPU
fpu_gnt_i  input  1  FPU grant
fpu_type_o  output  TYPE_WIDTH  selected type
fpu_operands_o  output  NB_ARGS*DATA_WIDTH  selected operands
fpu_op_o  output  OPCODE_WIDTH  selected opcode
fpu_flags_o  output  DSFLAGS_WIDTH  selected flags
fpu_rready_o  output  1  response ready to FPU
fpu_rvalid_i  input  1  FPU response valid
fpu_rdata_i  input  DATA_WIDTH  FPU result
fpu_rflags_i  input  USFLAGS_WIDTH  FPU result flags
err_o  output  1  sticky spurious-response error

Behaviour:
- State: rr_ptr (log2 NB_CORES), ID FIFO (MAX_OUTSTANDING x log2 NB_CORES, wr/rd pointers, count 0..MAX_OUTSTANDING), err flag.
- Reset (async, rst=1): rr_ptr=0, count=0, pointers=0, err_o=0. Resulting outputs: core_rvalid_o=0, fpu_rready_o=0. Grant outputs stay combinational and are 0 unless a request is present and count<MAX_OUTSTANDING. Reset mid-operation discards all in-flight IDs; responses arriving later count as spurious.
- Arbitration (combinational): sel = first i with core_req_i[i]=1, searching from rr_ptr upward with wrap-around.
- Full = (count==MAX_OUTSTANDING). fpu_req_o = (|core_req_i) & !full. Request-channel fields are muxed from sel. Field outputs are don't-care when no request is present; drive core 0's fields.
- core_gnt_o[sel] = fpu_gnt_i & fpu_req_o. All other grant bits are 0. At most one grant bit is high.
- Accept = fpu_req_o & fpu_gnt_i. On accept: push sel into the FIFO and set rr_ptr <= (sel+1) mod NB_CORES. Without an accept, rr_ptr holds.
- A core keeps its request and fields stable until granted. The arbiter does not require this, but sel may change while req drops.
- Response routing: head = FIFO[rd_ptr]. If count>0: core_rvalid_o[head] = fpu_rvalid_i, fpu_rready_o = core_rready_i[head], all other rvalid bits 0. core_rdata_o/core_rflags_o = fpu_rdata_i/fpu_rflags_i passthrough (0 latency).
- Pop on fpu_rvalid_i & fpu_rready_o.
- Simultaneous push and pop: count unchanged, both pointers advance. A push at full cannot occur, because grants are blocked at full. A pop at full in the same cycle frees a slot only from the next cycle.
- Empty (count=0) with fpu_rvalid_i=1: all core_rvalid_o=0, fpu_rready_o=0, err_o<=1 (sticky until reset).
- Issue latency 0 cycles (combinational grant). Responses are strictly in issue order; the FPU port must return results in order.

Optional Feature:
FPU_ARB_STALL_CNT_EN: when defined, adds output port stall_cnt_o [31:0]. The counter increments each cycle that |core_req_i & full, or that fpu_req_o & !fpu_gnt_i. It saturates at 0xFFFFFFFF and resets to 0. When undefined, the port and counter are absent; no other behaviour changes.

Test Plan:
- Single request: core 2 requests, fpu_gnt_i=1 -> core_gnt_o=4'b0100 same cycle, FIFO count=1; fpu_rvalid_i=1, rdata=0x3F800000, core_rready_i[2]=1 -> core_rvalid_o=4'b0100, rdata=0x3F800000, count=0.
- Round-robin: all 4 cores request continuously, fpu_gnt_i=1, responses returned in order -> grants in order core0,1,2,3,0; each core receives only its own result.
- Full stall: MAX_OUTSTANDING=4, issue 4 ops with no responses -> 5th request sees fpu_req_o=0 and core_gnt_o=0. One response popped -> grant resumes the next cycle.
- Backpressure: head core holds core_rready_i=0 for 3 cycles with fpu_rvalid_i=1 -> fpu_rready_o=0 and FIFO unchanged; the pop happens in the cycle rready rises.
- Spurious response: count=0, fpu_rvalid_i=1 -> no core_rvalid_o, fpu_rready_o=0, err_o=1 next cycle and stays 1 until rst.
- Reset mid-operation: assert rst with count=3 -> count=0, rr_ptr=0, err_o=0 immediately (asynchronous). With FPU_ARB_STALL_CNT_EN defined, stall_cnt_o=0.

Source files
------------

// File: rtl/fpu_core_arbiter.sv
// Round-robin arbiter sharing one FPU port among NB_CORES cores, with an in-order ID FIFO for response routing.
// Optional FPU_ARB_STALL_CNT_EN adds a saturating stall counter output stall_cnt_o.
module fpu_core_arbiter #(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NB_ARGS         = 3,
    parameter int unsigned OPCODE_WIDTH    = 6,
    parameter int unsigned TYPE_WIDTH      = 5,
    parameter int unsigned DSFLAGS_WIDTH   = 15,
    parameter int unsigned USFLAGS_WIDTH   = 5,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NB_CORES-1:0]                      core_req_i,
    output logic [NB_CORES-1:0]                      core_gnt_o,
    input  logic [NB_CORES*TYPE_WIDTH-1:0]           core_type_i,
    input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0]   core_operands_i,
    input  logic [NB_CORES*OPCODE_WIDTH-1:0]         core_op_i,
    input  logic [NB_CORES*DSFLAGS_WIDTH-1:0]        core_flags_i,
    input  logic [NB_CORES-1:0]                      core_rready_i,
    output logic [NB_CORES-1:0]                      core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    core_rdata_o,
    output logic [USFLAGS_WIDTH-1:0]                 core_rflags_o,
    output logic                                     fpu_req_o,
    input  logic                                     fpu_gnt_i,
    output logic [TYPE_WIDTH-1:0]                    fpu_type_o,
    output logic [NB_ARGS*DATA_WIDTH-1:0]            fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                  fpu_op_o,
    output logic [DSFLAGS_WIDTH-1:0]                 fpu_flags_o,
    output logic                                     fpu_rready_o,
    input  logic                                     fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                    fpu_rdata_i,
    input  logic [USFLAGS_WIDTH-1:0]                 fpu_rflags_i,
`ifdef FPU_ARB_STALL_CNT_EN
    output logic                                     err_o,
    output logic [31:0]                              stall_cnt_o
`else
    output logic                                     err_o
`endif
);

    localparam int unsigned IDW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int unsigned PW  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned OPW = NB_ARGS * DATA_WIDTH;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;
    logic [IDW-1:0] rr_next;
    logic [IDW-1:0] id_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           accept;
    logic           pop;

    // Search starts at rr_ptr and wraps; defaults to core 0 when nobody requests.
    always_comb begin : arbitrate
        logic           hit;
        logic [IDW-1:0] cand;
        hit  = 1'b0;
        sel  = '0;
        cand = '0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            cand = IDW'((32'(rr_ptr) + i) % NB_CORES);
            if (!hit && core_req_i[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
    end

    assign full      = (count == CW'(MAX_OUTSTANDING));
    assign empty     = (count == '0);
    assign fpu_req_o = (|core_req_i) & ~full;
    assign accept    = fpu_req_o & fpu_gnt_i;
    assign rr_next   = (sel == IDW'(NB_CORES - 1)) ? '0 : sel + IDW'(1);

    assign fpu_type_o     = core_type_i[sel*TYPE_WIDTH +: TYPE_WIDTH];
    assign fpu_operands_o = core_operands_i[sel*OPW +: OPW];
    assign fpu_op_o       = core_op_i[sel*OPCODE_WIDTH +: OPCODE_WIDTH];
    assign fpu_flags_o    = core_flags_i[sel*DSFLAGS_WIDTH +: DSFLAGS_WIDTH];

    always_comb begin
        core_gnt_o = '0;
        if (accept) core_gnt_o[sel] = 1'b1;
    end

    assign head = id_fifo[rd_ptr];

    // An empty FIFO swallows nothing: a response with no owner is left unacknowledged and flagged.
    always_comb begin
        core_rvalid_o = '0;
        fpu_rready_o  = 1'b0;
        if (!empty) begin
            core_rvalid_o[head] = fpu_rvalid_i;
            fpu_rready_o        = core_rready_i[head];
        end
    end

    assign pop           = fpu_rvalid_i & fpu_rready_o;
    assign core_rdata_o  = fpu_rdata_i;
    assign core_rflags_o = fpu_rflags_i;

    always_ff @(posedge clk) begin
        if (accept) id_fifo[wr_ptr] <= sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
                rr_ptr <= rr_next;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (empty && fpu_rvalid_i) err_o <= 1'b1;
        end
    end

`ifdef FPU_ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if ((((|core_req_i) & full) | (fpu_req_o & ~fpu_gnt_i)) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_core_arbiter.sv
// Randomized and directed scoreboard bench for fpu_core_arbiter (default build, stall counter absent).
module tb_fpu_core_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int NA = 3;
    localparam int OW = 6;
    localparam int TW = 5;
    localparam int FW = 15;
    localparam int UW = 5;
    localparam int MO = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         core_req_i;
    logic [N-1:0]         core_gnt_o;
    logic [N*TW-1:0]      core_type_i;
    logic [N*NA*DW-1:0]   core_operands_i;
    logic [N*OW-1:0]      core_op_i;
    logic [N*FW-1:0]      core_flags_i;
    logic [N-1:0]         core_rready_i;
    logic [N-1:0]         core_rvalid_o;
    logic [DW-1:0]        core_rdata_o;
    logic [UW-1:0]        core_rflags_o;
    logic                 fpu_req_o;
    logic                 fpu_gnt_i;
    logic [TW-1:0]        fpu_type_o;
    logic [NA*DW-1:0]     fpu_operands_o;
    logic [OW-1:0]        fpu_op_o;
    logic [FW-1:0]        fpu_flags_o;
    logic                 fpu_rready_o;
    logic                 fpu_rvalid_i;
    logic [DW-1:0]        fpu_rdata_i;
    logic [UW-1:0]        fpu_rflags_i;
    logic                 err_o;

    always #5 clk = ~clk;

    fpu_core_arbiter #(
        .NB_CORES(N), .DATA_WIDTH(DW), .NB_ARGS(NA), .OPCODE_WIDTH(OW),
        .TYPE_WIDTH(TW), .DSFLAGS_WIDTH(FW), .USFLAGS_WIDTH(UW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_type_i(core_type_i),
        .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
        .core_rready_i(core_rready_i), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i), .fpu_type_o(fpu_type_o),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
        .fpu_rready_o(fpu_rready_o), .fpu_rvalid_i(fpu_rvalid_i),
        .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i), .err_o(err_o)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    exp_t         sb_q[$];
    logic [31:0]  pend_d[$];
    logic [4:0]   pend_f[$];
    int           mq[$];
    int           rr;
    bit           merr;

    bit           r_req [N];
    logic [95:0]  r_ops [N];
    logic [5:0]   r_op  [N];
    logic [4:0]   r_typ [N];
    logic [14:0]  r_flg [N];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] res_of(logic [95:0] ops, logic [5:0] op, logic [4:0] t, logic [14:0] f);
        return ops[31:0] ^ ops[63:32] ^ ops[95:64] ^ {op, t, f, 6'd0};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete(); sb_q.delete(); pend_d.delete(); pend_f.delete();
        rr = 0; merr = 1'b0;
        for (int i = 0; i < N; i++) r_req[i] = 1'b0;
    endtask

    task automatic drive_cores();
        for (int i = 0; i < N; i++) begin
            core_req_i[i]                = r_req[i];
            core_operands_i[i*96 +: 96]  = r_ops[i];
            core_op_i[i*OW +: OW]        = r_op[i];
            core_type_i[i*TW +: TW]      = r_typ[i];
            core_flags_i[i*FW +: FW]     = r_flg[i];
        end
    endtask

    task automatic raise(int i);
        r_req[i] = 1'b1;
        r_ops[i] = {$urandom, $urandom, $urandom};
        r_op[i]  = 6'($urandom);
        r_typ[i] = 5'($urandom);
        r_flg[i] = 15'($urandom);
    endtask

    task automatic gen_cores(int pct);
        for (int i = 0; i < N; i++)
            if (!r_req[i] && $urandom_range(0, 99) < pct) raise(i);
    endtask

    task automatic fpu_drive(bit want);
        if (want && pend_d.size() > 0) begin
            fpu_rvalid_i = 1'b1;
            fpu_rdata_i  = pend_d[0];
            fpu_rflags_i = pend_f[0];
        end else begin
            fpu_rvalid_i = 1'b0;
            fpu_rdata_i  = $urandom;
            fpu_rflags_i = 5'($urandom);
        end
    endtask

    // Inputs are already applied at the falling edge; check combinational outputs, then advance the model.
    task automatic step();
        int         sel, bestd, d, head, sz;
        bit         exp_req, exp_rready, acc;
        logic [N-1:0] exp_gnt, exp_rv;
        #1;
        sz = mq.size();
        sel = 0; bestd = N;
        for (int c = 0; c < N; c++) begin
            d = (c + N - rr) % N;
            if (core_req_i[c] && d < bestd) begin bestd = d; sel = c; end
        end
        exp_req = (core_req_i != '0) && (sz < MO);
        acc     = exp_req && fpu_gnt_i;
        exp_gnt = '0;
        if (acc) exp_gnt[sel] = 1'b1;
        head       = (sz > 0) ? mq[0] : 0;
        exp_rready = (sz > 0) ? core_rready_i[head] : 1'b0;
        exp_rv     = '0;
        if (sz > 0) exp_rv[head] = fpu_rvalid_i;

        check("fpu_req", 128'(fpu_req_o), 128'(exp_req));
        check("core_gnt", 128'(core_gnt_o), 128'(exp_gnt));
        if (exp_req)
            check("fields", {fpu_type_o, fpu_op_o, fpu_flags_o, fpu_operands_o},
                  {r_typ[sel], r_op[sel], r_flg[sel], r_ops[sel]});
        check("fpu_rready", 128'(fpu_rready_o), 128'(exp_rready));
        check("core_rvalid", 128'(core_rvalid_o), 128'(exp_rv));
        check("err", 128'(err_o), 128'(merr));

        if (!rst) begin
            if (sz > 0 && fpu_rvalid_i && exp_rready) begin
                void'(mq.pop_front());
                if (pend_d.size() > 0) begin void'(pend_d.pop_front()); void'(pend_f.pop_front()); end
            end
            if (sz == 0 && fpu_rvalid_i) merr = 1'b1;
            if (acc) begin
                mq.push_back(sel);
                sb_q.push_back('{sel, res_of(r_ops[sel], r_op[sel], r_typ[sel], r_flg[sel]), r_op[sel][4:0]});
                pend_d.push_back(res_of(fpu_operands_o, fpu_op_o, fpu_type_o, fpu_flags_o));
                pend_f.push_back(fpu_op_o[4:0]);
                rr = (sel + 1) % N;
                r_req[sel] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Response monitor: every delivered result must belong to the oldest issued op.
    initial begin
        exp_t e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            #2;
            if ((core_rvalid_o != '0) && fpu_rready_o) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 128'(core_rvalid_o), 128'(0));
                end else begin
                    e  = sb_q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    check("resp_route", 128'(core_rvalid_o), 128'(oh));
                    check("resp_data", 128'(core_rdata_o), 128'(e.data));
                    check("resp_flags", 128'(core_rflags_o), 128'(e.flags));
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < N; i++) r_req[i] = 1'b0;
        for (int k = 0; k < 60 && mq.size() > 0; k++) begin
            drive_cores(); fpu_gnt_i = 1'b0; core_rready_i = '1; fpu_drive(1'b1);
            step();
        end
        fpu_drive(1'b0);
        #3;
        check("sb_drain", 128'(sb_q.size()), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        fpu_gnt_i = 1'b0; core_rready_i = '0;
        for (int i = 0; i < N; i++) begin r_ops[i] = '0; r_op[i] = '0; r_typ[i] = '0; r_flg[i] = '0; end
        model_reset(); drive_cores(); fpu_drive(1'b0);
        @(negedge clk);
        step();
        rst = 1'b0;
        step();

        // Single request from core 2 with a result of 1.0f
        r_req[2] = 1'b1; r_ops[2] = {64'd0, 32'h3F80_0000}; r_op[2] = '0; r_typ[2] = '0; r_flg[2] = '0;
        drive_cores(); fpu_gnt_i = 1'b1;
        step();
        drive_cores(); fpu_gnt_i = 1'b0; core_rready_i = '1; fpu_drive(1'b1);
        check("single_rdata", 128'(fpu_rdata_i), 128'(32'h3F80_0000));
        step();

        // All cores requesting, results returned continuously
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) if (!r_req[i]) raise(i);
            drive_cores(); fpu_gnt_i = 1'b1; core_rready_i = '1; fpu_drive(1'b1);
            step();
        end
        drain();

        // Fill to capacity, then release one slot
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) if (!r_req[i]) raise(i);
            drive_cores(); fpu_gnt_i = 1'b1; core_rready_i = '1; fpu_drive(1'b0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            drive_cores(); fpu_gnt_i = 1'b1; core_rready_i = '1; fpu_drive(k == 0);
            step();
        end

        // Head core backpressures for three cycles
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) r_req[i] = 1'b0;
            drive_cores(); fpu_gnt_i = 1'b0;
            core_rready_i = (k < 3) ? '0 : '1;
            fpu_drive(1'b1);
            step();
        end
        drain();

        // Spurious response on an empty FIFO
        fpu_rvalid_i = 1'b1; fpu_rdata_i = $urandom;
        step();
        fpu_drive(1'b0);
        step();
        step();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            gen_cores(40);
            drive_cores();
            fpu_gnt_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) core_rready_i[i] = ($urandom_range(0, 3) != 0);
            fpu_drive($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        // Reset with three ops in flight; late responses become spurious
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) r_req[i] = 1'b0;
            raise(k);
            drive_cores(); fpu_gnt_i = 1'b1; core_rready_i = '1; fpu_drive(1'b0);
            step();
        end
        for (int i = 0; i < N; i++) r_req[i] = 1'b0;
        drive_cores(); fpu_gnt_i = 1'b0;
        fpu_rvalid_i = 1'b1;
        rst = 1'b1;
        model_reset();
        step();
        fpu_rvalid_i = 1'b0;
        rst = 1'b0;
        step();
        fpu_rvalid_i = 1'b1;
        step();
        fpu_rvalid_i = 1'b0;
        step();
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
